// File: rtl/serial_demux_8_pkg.sv
// Shared definitions for the 8-lane serial demultiplexer: lane count,
// lane-index width and the frame-capture state encoding.
package serial_demux_8_pkg;

  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/serial_demux_8_index_counter.sv
// Lane index counter: points at the next shadow bit to be written.
// clear wins over loadOne, which wins over increment. wrap flags the last lane.
module demux_index_counter
  import serial_demux_8_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clear,
  input  logic             loadOne,
  input  logic             increment,
  output logic [SEL_W-1:0] count,
  output logic             wrap
);

  // Index register; the top only raises a control on an accepted bit, so Enable gating lives there
  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      count <= '0;
    end else if (loadOne) begin
      count <= SEL_W'(1);
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

  // Last lane of the frame is the one that completes it
  always_comb begin
    wrap = (count == SEL_W'(LANES - 1));
  end

endmodule

// File: rtl/serial_demux_8.sv
// Serial-to-parallel demultiplexer: collects 8 serial bits (lane 0 first)
// into a shadow register and publishes the frame on DemuxOut when complete.
// A new Start mid-frame aborts the partial frame and restarts at lane 0.
module serial_demux_8
  import serial_demux_8_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Start,
  input  logic             Valid,
  input  logic             DataIn,
  output logic [LANES-1:0] DemuxOut,
  output logic [SEL_W-1:0] Sel,
  output logic             Busy,
  output logic             Done,
  output logic             Abort
);

  state_t           state;
  state_t           stateNext;
  logic             accept;
  logic             lastLane;
  logic             cntClear;
  logic             cntLoadOne;
  logic             cntInc;
  logic             doneNext;
  logic             abortNext;
  logic [LANES-1:0] shadow;
  logic [LANES-1:0] shadowNext;
  logic [LANES-1:0] demuxNext;

  assign accept = Enable & Valid;

  demux_index_counter indexCounter (
    .Clock     (Clock),
    .Reset     (Reset),
    .clear     (cntClear),
    .loadOne   (cntLoadOne),
    .increment (cntInc),
    .count     (Sel),
    .wrap      (lastLane)
  );

  // Next-state, shadow/output update and pulse decode for one accepted bit
  always_comb begin
    stateNext  = state;
    shadowNext = shadow;
    demuxNext  = DemuxOut;
    doneNext   = 1'b0;
    abortNext  = 1'b0;
    cntClear   = 1'b0;
    cntLoadOne = 1'b0;
    cntInc     = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (Start) begin
            shadowNext = {{(LANES-1){1'b0}}, DataIn};
            cntLoadOne = 1'b1;
            stateNext  = SHIFT;
          end
        end
        SHIFT: begin
          if (Start) begin
            // Restart: drop the partial frame so stale lanes cannot leak out
            abortNext  = 1'b1;
            shadowNext = {{(LANES-1){1'b0}}, DataIn};
            cntLoadOne = 1'b1;
          end else if (lastLane) begin
            // Final lane goes straight to the output alongside the stored lanes
            shadowNext[Sel] = DataIn;
            demuxNext       = {DataIn, shadow[LANES-2:0]};
            doneNext        = 1'b1;
            cntClear        = 1'b1;
            stateNext       = IDLE;
          end else begin
            shadowNext[Sel] = DataIn;
            cntInc          = 1'b1;
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // State, shadow and registered outputs; Enable low leaves everything as-is and pulses drop
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      shadow   <= '0;
      DemuxOut <= '0;
      Done     <= 1'b0;
      Abort    <= 1'b0;
    end else begin
      state    <= stateNext;
      shadow   <= shadowNext;
      DemuxOut <= demuxNext;
      Done     <= doneNext;
      Abort    <= abortNext;
    end
  end

  // Busy is a direct decode of the state register, so it is registered too
  assign Busy = (state == SHIFT);

endmodule

// File: tb/tb_serial_demux_8.sv
// Self-checking bench for serial_demux_8: directed scenarios plus random
// traffic, every cycle compared against a frame-level reference model.
module tb_serial_demux_8;

  logic       Clock;
  logic       Reset;
  logic       Enable;
  logic       Start;
  logic       Valid;
  logic       DataIn;
  logic [7:0] DemuxOut;
  logic [2:0] Sel;
  logic       Busy;
  logic       Done;
  logic       Abort;

  int errors;
  int checks;
  int doneCount;
  int abortCount;

  // Reference model: a list of bits collected for the current frame
  bit       mBits[8];
  int       mCount;
  bit       mBusy;
  bit [7:0] mOut;
  bit       mDone;
  bit       mAbort;

  serial_demux_8 dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .Start    (Start),
    .Valid    (Valid),
    .DataIn   (DataIn),
    .DemuxOut (DemuxOut),
    .Sel      (Sel),
    .Busy     (Busy),
    .Done     (Done),
    .Abort    (Abort)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelUpdate(input bit rst, input bit en, input bit st, input bit vld, input bit d);
    mDone  = 1'b0;
    mAbort = 1'b0;
    if (rst) begin
      mBusy  = 1'b0;
      mCount = 0;
      mOut   = '0;
    end else if (en && vld) begin
      if (st) begin
        if (mBusy) mAbort = 1'b1;
        mBits[0] = d;
        mCount   = 1;
        mBusy    = 1'b1;
      end else if (mBusy) begin
        mBits[mCount] = d;
        mCount++;
        if (mCount == 8) begin
          for (int i = 0; i < 8; i++) mOut[i] = mBits[i];
          mDone  = 1'b1;
          mBusy  = 1'b0;
          mCount = 0;
        end
      end
    end
  endtask

  // One clock: apply inputs, let the edge happen, then compare everything
  task automatic step(input bit rst, input bit en, input bit st, input bit vld, input bit d);
    Reset  = rst;
    Enable = en;
    Start  = st;
    Valid  = vld;
    DataIn = d;
    @(posedge Clock);
    modelUpdate(rst, en, st, vld, d);
    #1;
    checkEq("DemuxOut", 32'(DemuxOut), 32'(mOut));
    checkEq("Sel", 32'(Sel), 32'(mCount));
    checkEq("Busy", 32'(Busy), 32'(mBusy));
    checkEq("Done", 32'(Done), 32'(mDone));
    checkEq("Abort", 32'(Abort), 32'(mAbort));
    if (Done === 1'b1) doneCount++;
    if (Abort === 1'b1) abortCount++;
  endtask

  task automatic sendBits(input bit [7:0] b, input int first, input int last, input bit withStart, input int gap);
    for (int i = first; i <= last; i++) begin
      step(1'b0, 1'b1, withStart && (i == first), 1'b1, b[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'($urandom));
    end
  endtask

  task automatic clearCounts();
    doneCount  = 0;
    abortCount = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    mCount = 0;
    mBusy  = 1'b0;
    mOut   = '0;
    clearCounts();
    Reset = 1'b1; Enable = 1'b0; Start = 1'b0; Valid = 1'b0; DataIn = 1'b0;

    // Reset state, including with Enable high and Start/Valid active
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkEq("rst_out", 32'(DemuxOut), 32'h0);

    // Accept without Start in IDLE is ignored
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkEq("idle_ignore_busy", 32'(Busy), 32'h0);

    // Scenario 1: 1,0,1,1,0,0,1,0 LSB first
    clearCounts();
    sendBits(8'b01001101, 0, 7, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkEq("s1_out", 32'(DemuxOut), 32'h4D);
    checkEq("s1_done", 32'(doneCount), 32'd1);

    // Scenario 2: same frame with 3 idle cycles between bits
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    clearCounts();
    sendBits(8'b01001101, 0, 7, 1'b1, 3);
    checkEq("s2_out", 32'(DemuxOut), 32'h4D);
    checkEq("s2_done", 32'(doneCount), 32'd1);

    // Scenario 3: restart at bit 4, then a full 8'hA5 frame
    clearCounts();
    sendBits(8'hFF, 0, 3, 1'b1, 0);
    sendBits(8'hA5, 0, 7, 1'b1, 0);
    checkEq("s3_out", 32'(DemuxOut), 32'hA5);
    checkEq("s3_abort", 32'(abortCount), 32'd1);
    checkEq("s3_done", 32'(doneCount), 32'd1);

    // Scenario 4: Enable low for 5 cycles mid-frame while Valid toggles
    clearCounts();
    sendBits(8'h3C, 0, 3, 1'b1, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'($urandom), 1'(i % 2 == 0), 1'($urandom));
    checkEq("s4_sel_frozen", 32'(Sel), 32'd4);
    sendBits(8'h3C, 4, 7, 1'b0, 0);
    checkEq("s4_out", 32'(DemuxOut), 32'h3C);
    checkEq("s4_done", 32'(doneCount), 32'd1);

    // Scenario 5: reset at bit 6, then Valid without Start
    sendBits(8'hFF, 0, 5, 1'b1, 0);
    clearCounts();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkEq("s5_out", 32'(DemuxOut), 32'h0);
    checkEq("s5_sel", 32'(Sel), 32'h0);
    checkEq("s5_busy", 32'(Busy), 32'h0);
    checkEq("s5_pulses", 32'(doneCount + abortCount), 32'd0);

    // Scenario 6: back-to-back 8'hFF then 8'h00
    clearCounts();
    sendBits(8'hFF, 0, 7, 1'b1, 0);
    checkEq("s6_out1", 32'(DemuxOut), 32'hFF);
    sendBits(8'h00, 0, 7, 1'b1, 0);
    checkEq("s6_out2", 32'(DemuxOut), 32'h00);
    checkEq("s6_done", 32'(doneCount), 32'd2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) < 6),
           1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_demux_8.md
SERIAL_DEMUX_8 -- requirements
Module: serial_demux_8

Interface
REQ-001 SHALL provide one clock and a synchronous, active-high reset; the ports are named Clock and Reset.
REQ-002 SHALL have port Clock, input, 1 bit: sole clock, rising-edge active.
REQ-003 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port Enable, input, 1 bit: when low, all state freezes and inputs are ignored.
REQ-005 SHALL have port Start, input, 1 bit: marks the bit on DataIn as lane 0 of a new frame.
REQ-006 SHALL have port Valid, input, 1 bit: DataIn carries a frame bit this cycle.
REQ-007 SHALL have port DataIn, input, 1 bit: serial data, LSB (lane 0) first.
REQ-008 SHALL have port DemuxOut, output, 8 bits: last completed frame, where bit k is lane k.
REQ-009 SHALL have port Sel, output, 3 bits: index of the next lane to be captured.
REQ-010 SHALL have port Busy, output, 1 bit: frame in progress.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse when DemuxOut updates.
REQ-012 SHALL have port Abort, output, 1 bit: one-cycle pulse when an in-progress frame is discarded.

Function
REQ-013 SHALL qualify every capture with Enable&Valid ("accept"); an accept is evaluated at the rising edge.
REQ-014 SHALL implement two states, IDLE and SHIFT; Busy SHALL be high exactly in SHIFT.
REQ-015 In IDLE, accept&Start SHALL write DataIn into shadow bit 0, set Sel=1 and go to SHIFT.
REQ-016 In IDLE, accept without Start SHALL be ignored: no state change and no pulse.
REQ-017 In SHIFT, accept without Start SHALL write DataIn into shadow bit Sel and increment Sel by 1.
REQ-018 In SHIFT, the accept at Sel=7 SHALL capture the bit and copy the full 8-bit shadow, including that bit, to DemuxOut at the same edge.
REQ-019 At that same edge, Done SHALL be high for exactly the following cycle, Sel SHALL wrap to 0 and the state SHALL become IDLE.
REQ-020 In SHIFT, accept&Start SHALL pulse Abort, discard the partial shadow, write DataIn into shadow bit 0, set Sel=1 and remain in SHIFT.
REQ-021 Start without Valid SHALL have no effect in either state.
REQ-022 With Enable low, state, Sel, shadow and DemuxOut SHALL hold; Done and Abort SHALL be 0.
REQ-023 In SHIFT, Valid low SHALL hold Sel and the shadow; there is no timeout.
REQ-024 DemuxOut SHALL change only at frame completion, with capture-to-output latency of 0 cycles after the 8th accept edge.
REQ-025 Shadow bits not yet written in the current frame SHALL never reach DemuxOut.

Reset
REQ-026 Reset SHALL take priority over Enable and all other inputs.
REQ-027 On Reset: state=IDLE, Sel=0, shadow=0, DemuxOut=0, Busy=0, Done=0, Abort=0.
REQ-028 Reset asserted mid-frame SHALL discard the frame silently, with no Abort and no Done.
REQ-029 The first accept&Start after Reset deasserts SHALL begin a frame normally.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=0, SHIFT=1), LANES=8 and SEL_W=3.
REQ-031 The 3-bit lane index SHALL be one sub-module, demux_index_counter, with ports clear, load-one, increment and a wrap flag.
REQ-032 All outputs SHALL be registered, and no combinational path SHALL run from inputs to outputs.

Verification
REQ-033 Scenario 1: Reset, then 8 accepts of 1,0,1,1,0,0,1,0 with Start on the first -> DemuxOut=8'b01001101 and Done pulses once after the 8th accept.
REQ-034 Scenario 2: Valid gaps of 3 idle cycles inserted between frame bits -> DemuxOut is identical to scenario 1, Sel holds during the gaps, and Busy stays high.
REQ-035 Scenario 3: Start&Valid at bit 4 of a frame, then 8 bits of 8'hA5 -> Abort pulses once, DemuxOut=8'hA5 and no Done is issued for the aborted frame.
REQ-036 Scenario 4: Enable low for 5 cycles mid-frame while Valid toggles -> no captures, Sel frozen, and the frame completes correctly afterwards.
REQ-037 Scenario 5: Reset at bit 6, then Valid without Start -> outputs are all 0, with no Done and no Abort.
REQ-038 Scenario 6: two back-to-back frames 8'hFF then 8'h00, with Start immediately after Done -> two Done pulses, and DemuxOut reads 8'hFF then 8'h00.
